channel_status_controller: RTL and testbench

CHANNEL_STATUS_CONTROLLER -- requirements
Module: channel_status_controller

---
 rtl/channel_status_controller.sv | 89 ++++++++
 tb/tb_channel_status_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_status_controller.sv
// channel_status_controller: four-channel key-on/off status with tick-based note durations; define SSG_NOISE_EXCLUSIVE_EN to let only one channel own noise
module channel_status_controller #(
  parameter int TICK_DIV = 16
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       CmdValid,
  output logic       CmdReady,
  input  logic [1:0] CmdChannel,
  input  logic [1:0] CmdOp,
  input  logic [7:0] CmdDuration,
  output logic [7:0] Status,
  output logic [3:0] ChannelDone
);
  typedef enum logic {IDLE, APPLY} state_t;
  state_t state_q, state_d;
  logic rdy_q;
  logic [1:0] ch_q, op_q;
  logic [7:0] dur_q;
  logic [15:0] pre_q;
  logic tick, accept, apply;
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];
  logic [7:0] status_q, status_d;
  logic [3:0] done_q, done_d;
  assign CmdReady = rdy_q && state_q == IDLE;
  assign accept = CmdValid && CmdReady;
  assign apply = state_q == APPLY && op_q != 2'b11;
  assign tick = pre_q == 16'(TICK_DIV - 1);
  assign Status = status_q;
  assign ChannelDone = done_q;
  // Accept in IDLE, spend exactly one cycle applying, then return
  always_comb begin
    state_d = state_q == IDLE ? (accept ? APPLY : IDLE) : IDLE;
  end
  // Per-channel next state: tick countdown first, then preemption, then the command overrides
  always_comb begin
    status_d = status_q;
    done_d = '0;
    for (int n = 0; n < 4; n++) begin
      cnt_d[n] = cnt_q[n];
      if (tick && status_q[2*n+1] && cnt_q[n] != 8'd0) begin
        cnt_d[n] = cnt_q[n] - 8'd1;
        if (cnt_q[n] == 8'd1) begin
          status_d[2*n+:2] = 2'b00;
          done_d[n] = 1'b1;
        end
      end
`ifdef SSG_NOISE_EXCLUSIVE_EN
      if (apply && op_q == 2'b10 && ch_q != 2'(n) && status_q[2*n+:2] == 2'b11) begin
        status_d[2*n+:2] = 2'b00;
        cnt_d[n] = 8'd0;
        done_d[n] = 1'b0;
      end
`endif
      if (apply && ch_q == 2'(n)) begin
        status_d[2*n+:2] = op_q == 2'b00 ? 2'b00 : {1'b1, op_q[1]};
        cnt_d[n] = op_q == 2'b00 ? 8'd0 : dur_q;
        done_d[n] = 1'b0;
      end
    end
  end
  // State, captured command, free-running prescaler and channel registers
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      rdy_q <= 1'b0;
      ch_q <= '0;
      op_q <= '0;
      dur_q <= '0;
      pre_q <= '0;
      status_q <= '0;
      done_q <= '0;
      for (int n = 0; n < 4; n++) cnt_q[n] <= '0;
    end else begin
      state_q <= state_d;
      rdy_q <= 1'b1;
      if (accept) begin
        ch_q <= CmdChannel;
        op_q <= CmdOp;
        dur_q <= CmdDuration;
      end
      pre_q <= tick ? 16'd0 : pre_q + 16'd1;
      status_q <= status_d;
      done_q <= done_d;
      for (int n = 0; n < 4; n++) cnt_q[n] <= cnt_d[n];
    end
  end
endmodule

// File: tb/tb_channel_status_controller.sv
// tb_channel_status_controller: randomized and directed checks against a channel-level reference model
module tb_channel_status_controller;
  localparam int TD = 4;
`ifdef SSG_NOISE_EXCLUSIVE_EN
  localparam bit EXCL = 1'b1;
`else
  localparam bit EXCL = 1'b0;
`endif
  logic Clock = 0, nReset = 0, CmdValid = 0;
  logic [1:0] CmdChannel = 0, CmdOp = 2'b11;
  logic [7:0] CmdDuration = 0;
  logic CmdReady;
  logic [7:0] Status;
  logic [3:0] ChannelDone;
  int n_cmp = 0, n_bad = 0;
  bit m_en[4], m_nz[4];
  int m_cnt[4];
  bit m_busy, m_ready;
  int p_ch, p_op, p_dur, e;
  logic [3:0] m_done;

  always #5 Clock = ~Clock;

  channel_status_controller #(.TICK_DIV(TD)) dut (
    .Clock(Clock), .nReset(nReset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdChannel(CmdChannel), .CmdOp(CmdOp), .CmdDuration(CmdDuration),
    .Status(Status), .ChannelDone(ChannelDone)
  );

  function automatic logic [7:0] m_status();
    logic [7:0] s = '0;
    for (int n = 0; n < 4; n++) begin
      s[2*n+1] = m_en[n];
      s[2*n] = m_nz[n];
    end
    return s;
  endfunction

  task automatic m_reset();
    for (int n = 0; n < 4; n++) begin
      m_en[n] = 0; m_nz[n] = 0; m_cnt[n] = 0;
    end
    m_busy = 0; m_ready = 0; e = 0; m_done = '0;
  endtask

  task automatic cmd(input bit v, input int ch, input int op, input int dur);
    CmdValid = v; CmdChannel = 2'(ch); CmdOp = 2'(op); CmdDuration = 8'(dur);
  endtask

  task automatic step();
    bit own[4];
    @(posedge Clock);
    e++;
    m_done = '0;
    for (int n = 0; n < 4; n++) own[n] = m_en[n] && m_nz[n];
    if (e % TD == 0)
      for (int n = 0; n < 4; n++)
        if (m_en[n] && m_cnt[n] > 0) begin
          m_cnt[n]--;
          if (m_cnt[n] == 0) begin m_en[n] = 0; m_nz[n] = 0; m_done[n] = 1; end
        end
    if (m_busy) begin
      if (p_op != 3) begin
        if (EXCL && p_op == 2)
          for (int n = 0; n < 4; n++)
            if (n != p_ch && own[n]) begin m_en[n] = 0; m_nz[n] = 0; m_cnt[n] = 0; m_done[n] = 0; end
        m_en[p_ch] = p_op != 0;
        m_nz[p_ch] = p_op == 2;
        m_cnt[p_ch] = p_op == 0 ? 0 : p_dur;
        m_done[p_ch] = 0;
      end
      m_busy = 0;
    end else if (m_ready && CmdValid) begin
      m_busy = 1; p_ch = int'(CmdChannel); p_op = int'(CmdOp); p_dur = int'(CmdDuration);
    end
    m_ready = 1;
    #1;
  endtask

  task automatic do_reset();
    cmd(0, 0, 3, 0);
    nReset = 0;
    m_reset();
    #3;
    nReset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    nReset = 0;
    #1;
    n_cmp++; if (Status !== 8'h00) begin n_bad++; $display("FAIL reset_status: got %h expected 00", Status); end
    n_cmp++; if (ChannelDone !== 4'h0) begin n_bad++; $display("FAIL reset_done: got %h expected 0", ChannelDone); end
    n_cmp++; if (CmdReady !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", CmdReady); end
    nReset = 1;
    step();
    n_cmp++; if (CmdReady !== 1'b1) begin n_bad++; $display("FAIL ready_after_release: got %b expected 1", CmdReady); end
  endtask

  task automatic test_basic();
    do_reset();
    step();
    cmd(1, 1, 1, 0);
    step();
    cmd(0, 0, 3, 0);
    n_cmp++; if (CmdReady !== 1'b0) begin n_bad++; $display("FAIL basic_ready_low: got %b expected 0", CmdReady); end
    n_cmp++; if (Status !== 8'h00) begin n_bad++; $display("FAIL basic_status_early: got %h expected 00", Status); end
    step();
    n_cmp++; if (Status !== 8'h08) begin n_bad++; $display("FAIL basic_status: got %h expected 08", Status); end
    n_cmp++; if (CmdReady !== 1'b1) begin n_bad++; $display("FAIL basic_ready_back: got %b expected 1", CmdReady); end
  endtask

  task automatic test_expiry();
    int at = -1;
    do_reset();
    step();
    cmd(1, 0, 2, 3);
    step();
    cmd(0, 0, 3, 0);
    step();
    n_cmp++; if (Status[1:0] !== 2'b11) begin n_bad++; $display("FAIL expiry_keyon: got %b expected 11", Status[1:0]); end
    for (int i = 0; i < 40 && at < 0; i++) begin
      step();
      n_cmp++; if (Status !== m_status() || ChannelDone !== m_done) begin
        n_bad++; $display("FAIL expiry_track: got %h/%h expected %h/%h", Status, ChannelDone, m_status(), m_done);
      end
      if (ChannelDone == 4'b0001) at = e;
    end
    n_cmp++; if (at != 3 * TD) begin n_bad++; $display("FAIL expiry_edge: got %0d expected %0d", at, 3 * TD); end
    n_cmp++; if (Status[1:0] !== 2'b00) begin n_bad++; $display("FAIL expiry_off: got %b expected 00", Status[1:0]); end
    step();
    n_cmp++; if (ChannelDone !== 4'b0000) begin n_bad++; $display("FAIL expiry_pulse_len: got %b expected 0000", ChannelDone); end
  endtask

  task automatic test_noise();
    do_reset();
    step();
    cmd(1, 2, 2, 0);
    step();
    cmd(0, 0, 3, 0);
    step();
    n_cmp++; if (Status !== 8'h30) begin n_bad++; $display("FAIL noise_first: got %h expected 30", Status); end
    cmd(1, 3, 2, 0);
    step();
    cmd(0, 0, 3, 0);
    step();
    n_cmp++; if (Status !== (EXCL ? 8'hC0 : 8'hF0)) begin n_bad++; $display("FAIL noise_second: got %h expected %h", Status, EXCL ? 8'hC0 : 8'hF0); end
    n_cmp++; if (ChannelDone !== 4'h0) begin n_bad++; $display("FAIL noise_done: got %h expected 0", ChannelDone); end
  endtask

  task automatic test_retrigger();
    int gap = -1;
    do_reset();
    step();
    cmd(1, 0, 1, 2);
    step();
    cmd(0, 0, 3, 0);
    step();
    for (int i = 0; i < 20 && !(m_cnt[0] == 1 && (e + 2) % TD == 0); i++) step();
    cmd(1, 0, 1, 5);
    step();
    cmd(0, 0, 3, 0);
    step();
    n_cmp++; if (e % TD != 0) begin n_bad++; $display("FAIL retrig_align: got edge %0d expected a tick edge", e); end
    n_cmp++; if (Status[1:0] !== 2'b10) begin n_bad++; $display("FAIL retrig_status: got %b expected 10", Status[1:0]); end
    n_cmp++; if (ChannelDone[0] !== 1'b0) begin n_bad++; $display("FAIL retrig_done: got %b expected 0", ChannelDone[0]); end
    for (int i = 1; i <= 30 && gap < 0; i++) begin
      step();
      if (ChannelDone[0]) gap = i;
    end
    n_cmp++; if (gap != 5 * TD) begin n_bad++; $display("FAIL retrig_reload: got %0d cycles expected %0d", gap, 5 * TD); end
  endtask

  task automatic test_reset_apply();
    do_reset();
    step();
    cmd(1, 1, 1, 0);
    step();
    cmd(0, 0, 3, 0);
    step();
    cmd(1, 3, 2, 0);
    step();
    cmd(0, 0, 3, 0);
    nReset = 0;
    m_reset();
    #1;
    n_cmp++; if (Status !== 8'h00) begin n_bad++; $display("FAIL rstapply_now: got %h expected 00", Status); end
    #2;
    nReset = 1;
    step(); step(); step();
    n_cmp++; if (Status !== 8'h00) begin n_bad++; $display("FAIL rstapply_after: got %h expected 00", Status); end
  endtask

  task automatic test_back_to_back();
    int ch[4] = '{2, 0, 3, 1};
    int op[4];
    int idx = 0, steps = 0;
    bit rb;
    logic [7:0] exp_s = '0;
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      op[i] = $urandom_range(1, 2);
      if (EXCL && op[i] == 2)
        for (int n = 0; n < 4; n++) if (exp_s[2*n+:2] == 2'b11) exp_s[2*n+:2] = 2'b00;
      exp_s[2*ch[i]+:2] = {1'b1, op[i] == 2};
    end
    while (idx < 4 && steps < 20) begin
      cmd(1, ch[idx], op[idx], 0);
      rb = CmdReady;
      step();
      steps++;
      if (rb) idx++;
      n_cmp++; if (CmdReady !== !rb) begin n_bad++; $display("FAIL b2b_ready: got %b expected %b", CmdReady, !rb); end
    end
    cmd(0, 0, 3, 0);
    step();
    n_cmp++; if (steps != 7) begin n_bad++; $display("FAIL b2b_rate: got %0d cycles expected 7", steps); end
    n_cmp++; if (Status !== exp_s) begin n_bad++; $display("FAIL b2b_status: got %h expected %h", Status, exp_s); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      cmd($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
      step();
      n_cmp++; if (Status !== m_status()) begin n_bad++; $display("FAIL rand_status: got %h expected %h", Status, m_status()); end
      n_cmp++; if (ChannelDone !== m_done) begin n_bad++; $display("FAIL rand_done: got %h expected %h", ChannelDone, m_done); end
      n_cmp++; if (CmdReady !== (m_ready && !m_busy)) begin n_bad++; $display("FAIL rand_ready: got %b expected %b", CmdReady, m_ready && !m_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_expiry();
    test_noise();
    test_retrigger();
    test_reset_apply();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
